// File: rtl/tx_samples_sequencer_if.sv
// Host-side bundle for the TX sample sequencer: buffer write port, playback control and
// streamed sample output.
`timescale 1ns / 1ps

interface tx_samples_sequencer_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 9
);
    logic                  etx_en;
    logic                  iwr_en;
    logic [ADDR_WIDTH-1:0] iwr_addr;
    logic [DATA_WIDTH-1:0] iwr_data;
    logic                  istart;
    logic [ADDR_WIDTH-1:0] ilength;
    logic                  inew_sample_trig;
    logic [DATA_WIDTH-1:0] odata_out;
    logic                  ovalid;
    logic                  obusy;
    logic                  odone;
    logic                  ounderrun;

    modport master (
        output etx_en,
        output iwr_en,
        output iwr_addr,
        output iwr_data,
        output istart,
        output ilength,
        output inew_sample_trig,
        input  odata_out,
        input  ovalid,
        input  obusy,
        input  odone,
        input  ounderrun
    );

    modport slave (
        input  etx_en,
        input  iwr_en,
        input  iwr_addr,
        input  iwr_data,
        input  istart,
        input  ilength,
        input  inew_sample_trig,
        output odata_out,
        output ovalid,
        output obusy,
        output odone,
        output ounderrun
    );
endinterface

// File: rtl/tx_samples_sequencer.sv
// Plays a host-loaded frame of signed samples out of a 1-cycle-latency buffer, one sample
// per sample-rate trigger, with a single-entry prefetch register hiding the read latency.
`timescale 1ns / 1ps

module tx_samples_sequencer #(
    parameter int unsigned MEMORY_LENGTH = 510,
    parameter int unsigned DATA_WIDTH    = 16,
    parameter int unsigned ADDR_WIDTH    = 9
) (
    input logic                 ctx_clk,
    input logic                 rtx_rst,
    tx_samples_sequencer_if.slave bus
);

    localparam logic [ADDR_WIDTH-1:0] MemLen = ADDR_WIDTH'(MEMORY_LENGTH);

    typedef enum logic [1:0] {
        StIdle,
        StPrime,
        StStream,
        StDone
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] len_q, len_d;
    logic [ADDR_WIDTH-1:0] count_q, count_d;
    logic [ADDR_WIDTH-1:0] count_inc;
    logic [DATA_WIDTH-1:0] prefetch_q, prefetch_d;
    logic                  reload_q, reload_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  done_q, done_d;
    logic                  underrun_q, underrun_d;

    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  wr_ok;
    logic                  busy;
    logic                  trig;

    logic [DATA_WIDTH-1:0] mem [MEMORY_LENGTH];

    assign busy      = (state_q == StPrime) || (state_q == StStream);
    assign wr_ok     = bus.iwr_en && !busy && (bus.iwr_addr < MemLen);
    assign trig      = bus.inew_sample_trig && bus.etx_en;
    assign count_inc = count_q + ADDR_WIDTH'(1);

    // Read-first: a write and a read of the same address on one edge return the old word.
    always_ff @(posedge ctx_clk) begin
        if (wr_ok) begin
            mem[bus.iwr_addr] <= bus.iwr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        count_d    = count_q;
        prefetch_d = prefetch_q;
        reload_d   = 1'b0;
        data_d     = data_q;
        valid_d    = 1'b0;
        done_d     = 1'b0;
        underrun_d = underrun_q;
        rd_en      = 1'b0;
        rd_addr    = '0;

        unique case (state_q)
            StIdle: begin
                if (bus.istart && bus.etx_en && (bus.ilength != '0)) begin
                    len_d      = (bus.ilength > MemLen) ? MemLen : bus.ilength;
                    count_d    = '0;
                    underrun_d = 1'b0;
                    rd_en      = 1'b1;
                    rd_addr    = '0;
                    state_d    = StPrime;
                end
            end

            StPrime: begin
                if (bus.etx_en) begin
                    prefetch_d = rd_data_q;
                    if (len_q > ADDR_WIDTH'(1)) begin
                        rd_en   = 1'b1;
                        rd_addr = ADDR_WIDTH'(1);
                    end
                    // Nothing is ready to emit yet, so a trigger here is lost.
                    if (bus.inew_sample_trig) begin
                        underrun_d = 1'b1;
                    end
                    state_d = StStream;
                end
            end

            StStream: begin
                if (reload_q) begin
                    prefetch_d = rd_data_q;
                end
                if (trig) begin
                    if (reload_q) begin
                        underrun_d = 1'b1;
                    end else begin
                        data_d  = prefetch_q;
                        valid_d = 1'b1;
                        count_d = count_inc;
                        if (count_inc < len_q) begin
                            rd_en    = 1'b1;
                            rd_addr  = count_inc;
                            reload_d = 1'b1;
                        end else begin
                            state_d = StDone;
                        end
                    end
                end
            end

            StDone: begin
                if (bus.etx_en) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge ctx_clk) begin
        if (!rtx_rst) begin
            state_q    <= StIdle;
            len_q      <= '0;
            count_q    <= '0;
            prefetch_q <= '0;
            reload_q   <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            count_q    <= count_d;
            prefetch_q <= prefetch_d;
            reload_q   <= reload_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            done_q     <= done_d;
            underrun_q <= underrun_d;
        end
    end

    assign bus.odata_out = data_q;
    assign bus.ovalid    = valid_q;
    assign bus.obusy     = busy;
    assign bus.odone     = done_q;
    assign bus.ounderrun = underrun_q;

endmodule

// File: tb/tb_tx_samples_sequencer.sv
// Bench for tx_samples_sequencer: frame-level reference model (buffer image plus queue of
// expected samples), cycle tables for the basic frame, directed corner cases, random frames.
`timescale 1ns / 1ps

module tb_tx_samples_sequencer;

    localparam int MemLen = 510;

    logic clk;
    logic rst_n;

    tx_samples_sequencer_if #(.DATA_WIDTH(16), .ADDR_WIDTH(9)) bus ();

    tx_samples_sequencer #(
        .MEMORY_LENGTH(510),
        .DATA_WIDTH   (16),
        .ADDR_WIDTH   (9)
    ) dut (
        .ctx_clk(clk),
        .rtx_rst(rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int valid_cnt = 0;
    int done_cnt  = 0;

    logic [15:0] ref_mem [512];
    logic [15:0] exp_q [$];

    typedef struct {
        logic        trig;
        logic        exp_valid;
        logic [15:0] exp_data;
        logic        exp_busy;
        logic        exp_done;
    } vec_t;

    vec_t vecs [22];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every emitted sample must be the next one the model expects.
    always @(negedge clk) begin
        if (bus.ovalid) begin
            valid_cnt++;
            if (exp_q.size() == 0) begin
                check("ovalid_with_sample_pending", 32'(exp_q.size() != 0), 1);
            end else begin
                check("sample_value", bus.odata_out, exp_q.pop_front());
            end
        end
        if (bus.odone) begin
            done_cnt++;
            check("odone_after_all_samples", exp_q.size(), 0);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic write(input int addr, input logic [15:0] data);
        bus.iwr_en   = 1'b1;
        bus.iwr_addr = 9'(addr);
        bus.iwr_data = data;
        tick;
        bus.iwr_en = 1'b0;
        if (addr < MemLen) ref_mem[addr] = data;
    endtask

    task automatic queue_frame(input int len);
        int n;
        n = (len > MemLen) ? MemLen : len;
        for (int k = 0; k < n; k++) exp_q.push_back(ref_mem[k]);
    endtask

    task automatic start(input int len, input bit prime_tick);
        bus.istart  = 1'b1;
        bus.ilength = 9'(len);
        tick;
        bus.istart = 1'b0;
        queue_frame(len);
        if (prime_tick) tick;
    endtask

    task automatic trig_once;
        bus.inew_sample_trig = 1'b1;
        tick;
        bus.inew_sample_trig = 1'b0;
    endtask

    task automatic play(input int max_gap, input bit rand_en);
        int d0;
        int guard;
        d0 = done_cnt;
        guard = 0;
        while (done_cnt == d0 && guard < 2000) begin
            bus.inew_sample_trig = 1'b1;
            if (rand_en && $urandom_range(0, 3) == 0) bus.etx_en = 1'b0;
            tick;
            bus.inew_sample_trig = 1'b0;
            bus.etx_en = 1'b1;
            repeat ($urandom_range(1, max_gap - 1)) tick;
            guard++;
        end
        check("frame_completed", done_cnt - d0, 1);
        check("queue_drained", exp_q.size(), 0);
        tick;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] vals [5];
        int v0, d0;
        vals = '{16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h1234};

        // Cycle table for the basic 5-sample frame, one trigger every 4 cycles.
        for (int i = 0; i < 22; i++) begin
            vecs[i].trig      = (i % 4 == 0) && (i <= 16);
            vecs[i].exp_valid = (i % 4 == 0) && (i <= 16);
            vecs[i].exp_data  = vals[(i > 16) ? 4 : i / 4];
            vecs[i].exp_busy  = (i < 16);
            vecs[i].exp_done  = (i == 17);
        end

        rst_n = 1'b0;
        bus.etx_en = 1'b1;
        bus.iwr_en = 1'b0;
        bus.iwr_addr = '0;
        bus.iwr_data = '0;
        bus.istart = 1'b0;
        bus.ilength = '0;
        bus.inew_sample_trig = 1'b0;
        repeat (3) tick;
        check("reset_data", bus.odata_out, 0);
        check("reset_valid", bus.ovalid, 0);
        check("reset_busy", bus.obusy, 0);
        check("reset_done", bus.odone, 0);
        check("reset_underrun", bus.ounderrun, 0);
        rst_n = 1'b1;
        tick;

        for (int a = 0; a < MemLen; a++) write(a, 16'($urandom));

        // Basic frame
        for (int a = 0; a < 5; a++) write(a, vals[a]);
        start(5, 1'b1);
        for (int i = 0; i < 22; i++) begin
            bus.inew_sample_trig = vecs[i].trig;
            tick;
            bus.inew_sample_trig = 1'b0;
            check($sformatf("t1_valid[%0d]", i), bus.ovalid, vecs[i].exp_valid);
            check($sformatf("t1_data[%0d]", i), bus.odata_out, vecs[i].exp_data);
            check($sformatf("t1_busy[%0d]", i), bus.obusy, vecs[i].exp_busy);
            check($sformatf("t1_done[%0d]", i), bus.odone, vecs[i].exp_done);
        end

        // Zero length is ignored; oversized length clamps to the buffer depth
        v0 = valid_cnt; d0 = done_cnt;
        start(0, 1'b1);
        check("len0_busy", bus.obusy, 0);
        repeat (5) tick;
        check("len0_no_valid", valid_cnt - v0, 0);
        check("len0_no_done", done_cnt - d0, 0);
        v0 = valid_cnt;
        start(511, 1'b1);
        check("len511_busy", bus.obusy, 1);
        play(2, 1'b0);
        check("len511_samples", valid_cnt - v0, 510);

        // Trigger in the priming cycle raises a sticky underrun
        v0 = valid_cnt;
        start(5, 1'b0);
        trig_once;
        check("prime_trig_underrun", bus.ounderrun, 1);
        check("prime_trig_no_valid", bus.ovalid, 0);
        tick;
        play(4, 1'b0);
        check("underrun_frame_samples", valid_cnt - v0, 5);
        check("underrun_sticky", bus.ounderrun, 1);
        start(5, 1'b1);
        check("underrun_cleared", bus.ounderrun, 0);
        play(3, 1'b0);

        // Enable low mid-frame freezes playback
        v0 = valid_cnt;
        start(5, 1'b1);
        trig_once; tick; tick;
        trig_once; tick; tick;
        bus.etx_en = 1'b0;
        for (int c = 0; c < 10; c++) begin
            bus.inew_sample_trig = (c == 2 || c == 6);
            tick;
            bus.inew_sample_trig = 1'b0;
            check($sformatf("en_low_no_valid[%0d]", c), bus.ovalid, 0);
            check($sformatf("en_low_busy[%0d]", c), bus.obusy, 1);
        end
        bus.etx_en = 1'b1;
        check("en_low_count_frozen", valid_cnt - v0, 2);
        check("en_low_no_underrun", bus.ounderrun, 0);
        play(3, 1'b0);
        check("en_low_total", valid_cnt - v0, 5);

        // Reset after the third sample aborts the frame
        start(5, 1'b1);
        repeat (3) begin trig_once; tick; tick; end
        rst_n = 1'b0;
        d0 = done_cnt;
        tick;
        exp_q.delete();
        check("mid_rst_data", bus.odata_out, 0);
        check("mid_rst_valid", bus.ovalid, 0);
        check("mid_rst_busy", bus.obusy, 0);
        check("mid_rst_done", bus.odone, 0);
        rst_n = 1'b1;
        repeat (4) tick;
        check("mid_rst_no_done", done_cnt - d0, 0);
        v0 = valid_cnt;
        start(5, 1'b1);
        play(3, 1'b0);
        check("restart_samples", valid_cnt - v0, 5);

        // Writes while busy are dropped
        start(5, 1'b1);
        trig_once; tick;
        bus.iwr_en = 1'b1; bus.iwr_addr = 9'd3; bus.iwr_data = 16'hAAAA;
        tick;
        bus.iwr_en = 1'b0;
        play(3, 1'b0);
        check("busy_write_dropped_model", ref_mem[3], 16'hFFFF);

        // Write coinciding with start: only addresses >= 1 are seen by this frame
        for (int a = 0; a < 3; a += 2) begin
            bus.iwr_en = 1'b1; bus.iwr_addr = 9'(a); bus.iwr_data = 16'h5A00 + 16'(a);
            bus.istart = 1'b1; bus.ilength = 9'd4;
            tick;
            bus.iwr_en = 1'b0; bus.istart = 1'b0;
            queue_frame(4);
            ref_mem[a] = 16'h5A00 + 16'(a);
            if (a >= 1) exp_q[a] = ref_mem[a];
            tick;
            play(3, 1'b0);
        end

        // Random frames
        for (int f = 0; f < 25; f++) begin
            int len;
            int sel;
            repeat ($urandom_range(0, 6)) write($urandom_range(0, 511), 16'($urandom));
            sel = $urandom_range(0, 9);
            len = (sel == 0) ? 0 : (sel == 1) ? $urandom_range(500, 511) : $urandom_range(1, 24);
            v0 = valid_cnt;
            start(len, 1'b1);
            if (len == 0) begin
                check("rand_len0_busy", bus.obusy, 0);
            end else begin
                play(4, 1'b1);
                check("rand_frame_samples", valid_cnt - v0, (len > MemLen) ? MemLen : len);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
